// File: rtl/ps2_pkg.sv
// PS/2 scancode receiver shared definitions: frame FSM state encoding,
// prefix byte constants and ps2_key event-word field positions.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam int KEY_TOGGLE   = 10;
    localparam int KEY_PRESSED  = 9;
    localparam int KEY_EXT      = 8;
    localparam int KEY_CODE_MSB = 7;

endpackage

// File: rtl/ps2_filter.sv
// PS/2 line conditioner: 2-flop synchronisers on clock and data, a
// FILTER-sample debounce of the clock line and a falling-edge pulse.
// Ports: clock, reset (async, active-high), ce (sample enable),
//        ps2_clk/ps2_dat (raw lines), dat_s (synchronised data),
//        fall (one-cycle pulse when the filtered clock goes 1->0).
module ps2_filter #(
    parameter int FILTER = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic ce,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic dat_s,
    output logic fall
);

    localparam int CW = $clog2(FILTER + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            level_q    <= 1'b1;
            cnt_q      <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
            level_q    <= level_d;
            cnt_q      <= cnt_d;
        end
    end

    // cnt_q counts consecutive samples that disagree with the filtered
    // level; any agreeing sample restarts the run.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        fall    = 1'b0;
        if (ce) begin
            if (clk_sync_q[1] == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(FILTER - 1)) begin
                level_d = ~level_q;
                cnt_d   = '0;
                fall    = level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign dat_s = dat_sync_q[1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scancode receiver: frames bytes, folds E0/F0 prefixes
// into an 11-bit event word {toggle, pressed, extended, scancode}.
// Ports: clock, reset (async, active-high), ce, ps2_clk, ps2_dat,
//        ps2_key[10:0] (event word), error (discarded-frame pulse).
// Optional: define PS2_TIMEOUT_EN to abort stalled frames after TIMEOUT.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int          FILTER  = 8,
    parameter logic [15:0] TIMEOUT = 16'd2000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [10:0] ps2_key,
    output logic        error
);

    logic dat_s;
    logic fall;

    ps2_filter #(.FILTER(FILTER)) u_filter (
        .clock   (clock),
        .reset   (reset),
        .ce      (ce),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .dat_s   (dat_s),
        .fall    (fall)
    );

    ps2_state_e  state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        brk_q, brk_d;
    logic        ext_q, ext_d;
    logic [10:0] key_q, key_d;
    logic        err_q, err_d;
    logic        tmo_hit;

`ifdef PS2_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d   = tmo_q;
        tmo_hit = 1'b0;
        if (fall) begin
            tmo_d = '0;
        end else if (ce && state_q != ST_IDLE) begin
            if (tmo_q == TIMEOUT - 16'd1) begin
                tmo_hit = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        brk_d    = brk_q;
        ext_d    = ext_q;
        key_d    = key_q;
        err_d    = 1'b0;
        if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!dat_s) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d  = {dat_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    // Odd parity: data plus parity bit hold an odd count of ones.
                    if (dat_s && ^{shift_q, par_q}) begin
                        if (shift_q == PS2_BREAK) begin
                            brk_d = 1'b1;
                        end else if (shift_q == PS2_EXT) begin
                            ext_d = 1'b1;
                        end else begin
                            key_d[KEY_CODE_MSB:0] = shift_q;
                            key_d[KEY_EXT]        = ext_q;
                            key_d[KEY_PRESSED]    = ~brk_q;
                            key_d[KEY_TOGGLE]     = ~key_q[KEY_TOGGLE];
                            brk_d                 = 1'b0;
                            ext_d                 = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (tmo_hit) begin
            state_d = ST_IDLE;
            brk_d   = 1'b0;
            ext_d   = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
            key_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            brk_q    <= brk_d;
            ext_q    <= ext_d;
            key_q    <= key_d;
            err_q    <= err_d;
        end
    end

    assign ps2_key = key_q;
    assign error   = err_q;

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 Parameter FILTER, default 8: number of consecutive equal ce-samples that qualify a ps2_clk level.
REQ-002 Parameter TIMEOUT, default 16'd2000: ce-cycles allowed between falling edges inside one frame.
REQ-003 clock  input  1  system clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ce  input  1  sample enable; line sampling and timeout counting advance only when ce=1.
REQ-006 ps2_clk  input  1  raw PS/2 clock line, asynchronous.
REQ-007 ps2_dat  input  1  raw PS/2 data line, asynchronous.
REQ-008 ps2_key  output  11  event word: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
REQ-009 error  output  1  one-clock pulse on a discarded frame.

Function
REQ-010 ps2_clk and ps2_dat shall pass through a 2-flop synchroniser before use.
REQ-011 The filter shall report a falling edge only when the filtered level goes 1->0 after FILTER consecutive low samples, preceded by FILTER consecutive high samples.
REQ-012 ps2_dat shall be sampled at the synchronised value on the clock cycle the falling edge is reported.
REQ-013 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: an edge with data=0 shall go to DATA with bit count 0; an edge with data=1 shall be ignored, FSM stays IDLE, no error.
REQ-015 DATA: 8 edges shift in data LSB first, then go to PARITY.
REQ-016 PARITY: one edge samples parity bit, then go to STOP.
REQ-017 STOP: one edge; if stop=1 and the odd-parity check over 8 data + parity passes, the byte is accepted; otherwise error pulses and the byte is discarded; FSM returns to IDLE in either case.
REQ-018 Accepted 8'hF0 shall set the break flag and produce no event.
REQ-019 Accepted 8'hE0 shall set the extended flag and produce no event.
REQ-020 Any other accepted byte shall, on the clock after the stop edge, load ps2_key[7:0]=byte, [8]=extended flag, [9]=~break flag, invert [10], then clear both flags.
REQ-021 A discarded frame shall clear both flags.
REQ-022 All other bytes (E1, AA, FA, FE, ...) shall be emitted as ordinary events.
REQ-023 ps2_key shall hold its value between events; exactly one [10] toggle per event.
REQ-024 error shall be a single clock pulse, independent of ce.

Reset
REQ-025 reset shall force FSM=IDLE, bit count=0, flags=0, ps2_key=11'h000, error=0, filter state=high, timeout counter=0.
REQ-026 reset asserted mid-frame shall abandon the frame with no event and no error pulse.

Configuration
REQ-027 With PS2_TIMEOUT_EN defined, a counter shall clear on every reported edge and increment on each ce while FSM is not IDLE; reaching TIMEOUT shall return FSM to IDLE, clear the flags and pulse error.
REQ-028 Without PS2_TIMEOUT_EN, the counter shall not exist and a partial frame shall wait indefinitely.

Structure
REQ-029 Package ps2_pkg shall hold the FSM state encoding, the constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0, and the ps2_key field bit positions.
REQ-030 Sub-module ps2_filter shall contain the synchroniser, the FILTER-sample debounce and the falling-edge pulse; the top level shall contain the FSM, the prefix flags and the output register.

Verification
REQ-031 Frame 0x1C, parity 0, stop 1 -> ps2_key=={~old[10],1,0,8'h1C} one clock after the stop edge; error stays 0.
REQ-032 Frames F0,1C -> only one event, ps2_key[9:0]==10'h01C, with [9]=0.
REQ-033 Frames E0,F0,75 -> one event with [8]=1, [9]=0, [7:0]=8'h75; the next plain frame 0x75 gives [8]=0, [9]=1.
REQ-034 Frame 0x1C with wrong parity, or with stop=0 -> error pulses once, no toggle; a following E0 flag is not inherited from before the bad frame.
REQ-035 With PS2_TIMEOUT_EN: stop after 4 data bits, idle TIMEOUT ce-cycles -> error pulse, FSM=IDLE; the next valid frame 0x29 decodes correctly.
REQ-036 A 3-sample low glitch on ps2_clk with FILTER=8 -> no edge counted; reset asserted mid-frame -> ps2_key==11'h000, no error.
